// File: rtl/div_requester_pkg.sv
// Shared types for the divider requester: FSM states, default operand width, result record.
package div_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RELEASE
  } div_state_t;

  typedef struct packed {
    logic [DIV_WIDTH-1:0] q;
    logic [DIV_WIDTH-1:0] r;
    logic                 dbz;
    logic                 to;
  } div_res_t;

endpackage

// File: rtl/div_requester_if.sv
// Command source, divider handshake and result sink of the divider requester.
interface div_requester_if #(
  parameter int WIDTH = div_pkg::DIV_WIDTH
);

  logic             CMD_VALID;
  logic             CMD_READY;
  logic [WIDTH-1:0] CMD_A;
  logic [WIDTH-1:0] CMD_D;
  logic             REQ;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] D;
  logic             ACK;
  logic             FDBZ;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             RES_VALID;
  logic             RES_READY;
  logic [WIDTH-1:0] RES_Q;
  logic [WIDTH-1:0] RES_R;
  logic             RES_DBZ;
  logic             RES_TO;
  logic             BUSY;

  modport master (
    input  CMD_VALID, CMD_A, CMD_D, ACK, FDBZ, Q, R, RES_READY,
    output CMD_READY, REQ, A, D, RES_VALID, RES_Q, RES_R, RES_DBZ, RES_TO, BUSY
  );

  modport slave (
    output CMD_VALID, CMD_A, CMD_D, ACK, FDBZ, Q, R, RES_READY,
    input  CMD_READY, REQ, A, D, RES_VALID, RES_Q, RES_R, RES_DBZ, RES_TO, BUSY
  );

endinterface

// File: rtl/div_requester_cmd_fifo.sv
// Synchronous command FIFO holding packed {A,D} pairs for the divider requester.
module div_cmd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full    = (count == (AW+1)'(DEPTH));
    empty   = (count == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    rdata   = mem[rptr];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/div_requester.sv
// Initiator side of the divider 4-phase REQ/ACK/FDBZ handshake: queues commands,
// issues them one at a time with a timeout, and returns one result per command.
module div_requester
  import div_pkg::*;
#(
  parameter int WIDTH   = DIV_WIDTH,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic           CLK,
  input  logic           RST,
  div_requester_if.master bus
);

  localparam int             CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  CNT_MAX  = '1;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
    logic             to;
  } res_t;

  div_state_t       state, state_n;
  logic [CW-1:0]    cnt;
  logic             req_q;
  logic [WIDTH-1:0] a_q, d_q;
  res_t             res_q, cap_res;
  logic             res_valid;

  logic             full, empty, cmd_ready, push, pop, cap, cnt_inc, slot_free;
  logic [2*WIDTH-1:0] head;

  // Readiness comes from the pre-pop count, so a full FIFO refuses a push even while popping.
  assign cmd_ready = !full && !RST;
  assign push      = bus.CMD_VALID && cmd_ready;
  assign slot_free = !res_valid || bus.RES_READY;

  div_cmd_fifo #(
    .WIDTH (2*WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .wdata ({bus.CMD_A, bus.CMD_D}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    cap     = 1'b0;
    cnt_inc = 1'b0;
    cap_res = '0;
    unique case (state)
      IDLE: begin
        if (!empty && !bus.ACK && !bus.FDBZ) begin
          pop     = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        // A response with a full slot holds REQ high and freezes the counter.
        if (bus.FDBZ || bus.ACK) begin
          if (slot_free) begin
            cap         = 1'b1;
            cap_res.dbz = bus.FDBZ;
            if (!bus.FDBZ) begin
              cap_res.q = bus.Q;
              cap_res.r = bus.R;
            end
            state_n = RELEASE;
          end
        end else if (cnt >= CNT_LAST && slot_free) begin
          cap        = 1'b1;
          cap_res.to = 1'b1;
          state_n    = RELEASE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RELEASE: begin
        if (!bus.ACK && !bus.FDBZ) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      req_q <= 1'b0;
      a_q   <= '0;
      d_q   <= '0;
      cnt   <= '0;
    end else if (pop) begin
      req_q      <= 1'b1;
      {a_q, d_q} <= head;
      cnt        <= '0;
    end else if (cap) begin
      req_q <= 1'b0;
    end else if (cnt_inc && cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      res_valid <= 1'b0;
      res_q     <= '0;
    end else if (cap) begin
      res_valid <= 1'b1;
      res_q     <= cap_res;
    end else if (res_valid && bus.RES_READY) begin
      res_valid <= 1'b0;
      res_q     <= '0;
    end
  end

  assign bus.CMD_READY = cmd_ready;
  assign bus.REQ       = req_q;
  assign bus.A         = a_q;
  assign bus.D         = d_q;
  assign bus.RES_VALID = res_valid;
  assign bus.RES_Q     = res_q.q;
  assign bus.RES_R     = res_q.r;
  assign bus.RES_DBZ   = res_q.dbz;
  assign bus.RES_TO    = res_q.to;
  assign bus.BUSY      = (state != IDLE) || !empty;

endmodule

// File: tb/tb_div_requester.sv
// Directed bench for div_requester against a behavioural 17-cycle 4-phase divider model.
module tb_div_requester;
  import div_pkg::*;

  localparam int W       = 16;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_requester_if #(.WIDTH(W)) bus ();

  div_requester #(
    .WIDTH   (W),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Divider model: ACK 17 edges after REQ is seen, FDBZ after 2 when D==0,
  // response held until REQ drops plus ack_extra cycles.
  logic         ack_m  = 1'b0;
  logic         fdbz_m = 1'b0;
  logic [W-1:0] q_m    = '0;
  logic [W-1:0] r_m    = '0;
  int           dcnt   = 0;
  int           hold   = 0;
  int           ack_extra = 0;
  bit           silent = 1'b0;
  logic         ack_ovr = 1'b0;

  assign bus.ACK  = ack_m | ack_ovr;
  assign bus.FDBZ = fdbz_m;
  assign bus.Q    = q_m;
  assign bus.R    = r_m;

  always @(posedge clk) begin
    if (silent) begin
      ack_m <= 1'b0; fdbz_m <= 1'b0; dcnt <= 0; hold <= 0;
    end else if (ack_m || fdbz_m) begin
      if (!bus.REQ) begin
        if (hold >= ack_extra) begin
          ack_m <= 1'b0; fdbz_m <= 1'b0; hold <= 0; q_m <= '0; r_m <= '0;
        end else hold <= hold + 1;
      end
    end else if (bus.REQ) begin
      if (bus.D == '0) begin
        if (dcnt == 1) begin fdbz_m <= 1'b1; dcnt <= 0; end
        else dcnt <= dcnt + 1;
      end else if (dcnt == 16) begin
        ack_m <= 1'b1; q_m <= bus.A / bus.D; r_m <= bus.A % bus.D; dcnt <= 0;
      end else dcnt <= dcnt + 1;
    end else dcnt <= 0;
  end

  task automatic push_cmd(input logic [W-1:0] a, input logic [W-1:0] d);
    int n;
    n = 0;
    @(negedge clk);
    bus.CMD_A = a; bus.CMD_D = d; bus.CMD_VALID = 1'b1;
    while (!bus.CMD_READY && n < 200) begin @(negedge clk); n++; end
    checks++; if (bus.CMD_READY !== 1'b1) begin failures++; $display("FAIL push_ready got=%b exp=1", bus.CMD_READY); end
    @(posedge clk); #1;
    bus.CMD_VALID = 1'b0;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while ((bus.BUSY || bus.ACK || bus.FDBZ) && n < 200) begin @(negedge clk); n++; end
    checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL idle_timeout busy=%b exp=0", bus.BUSY); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.REQ !== 1'b0)       begin failures++; $display("FAIL rst_req got=%b exp=0", bus.REQ); end
    checks++; if (bus.RES_VALID !== 1'b0) begin failures++; $display("FAIL rst_res_valid got=%b exp=0", bus.RES_VALID); end
    checks++; if (bus.BUSY !== 1'b0)      begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.BUSY); end
    checks++; if (bus.CMD_READY !== 1'b0) begin failures++; $display("FAIL rst_cmd_ready got=%b exp=0", bus.CMD_READY); end
    checks++; if (bus.RES_Q !== '0)       begin failures++; $display("FAIL rst_res_q got=%h exp=0000", bus.RES_Q); end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (bus.CMD_READY !== 1'b1) begin failures++; $display("FAIL post_rst_cmd_ready got=%b exp=1", bus.CMD_READY); end
    checks++; if (bus.REQ !== 1'b0)       begin failures++; $display("FAIL post_rst_req got=%b exp=0", bus.REQ); end
  endtask

  task automatic test_basic;
    int n;
    bit stable;
    bus.RES_READY = 1'b0;
    @(negedge clk);
    bus.CMD_A = 16'd9; bus.CMD_D = 16'd2; bus.CMD_VALID = 1'b1;
    checks++; if (bus.CMD_READY !== 1'b1) begin failures++; $display("FAIL basic_ready got=%b exp=1", bus.CMD_READY); end
    @(posedge clk); @(negedge clk);
    bus.CMD_VALID = 1'b0;
    checks++; if (bus.REQ !== 1'b0) begin failures++; $display("FAIL basic_req_early got=%b exp=0", bus.REQ); end
    @(posedge clk); @(negedge clk);
    checks++; if (bus.REQ !== 1'b1)  begin failures++; $display("FAIL basic_req_rise got=%b exp=1", bus.REQ); end
    checks++; if (bus.A !== 16'h0009) begin failures++; $display("FAIL basic_a got=%h exp=0009", bus.A); end
    checks++; if (bus.D !== 16'h0002) begin failures++; $display("FAIL basic_d got=%h exp=0002", bus.D); end
    n = 0; stable = 1'b1;
    while (!bus.RES_VALID && n < 100) begin
      if (!bus.REQ || bus.A !== 16'h0009 || bus.D !== 16'h0002) stable = 1'b0;
      @(negedge clk); n++;
    end
    checks++; if (n != 18)           begin failures++; $display("FAIL basic_latency got=%0d exp=18", n); end
    checks++; if (stable !== 1'b1)   begin failures++; $display("FAIL basic_req_stable got=%b exp=1", stable); end
    checks++; if (bus.RES_Q !== 16'h0004) begin failures++; $display("FAIL basic_q got=%h exp=0004", bus.RES_Q); end
    checks++; if (bus.RES_R !== 16'h0001) begin failures++; $display("FAIL basic_r got=%h exp=0001", bus.RES_R); end
    checks++; if ({bus.RES_DBZ, bus.RES_TO} !== 2'b00) begin failures++; $display("FAIL basic_flags got=%b exp=00", {bus.RES_DBZ, bus.RES_TO}); end
    checks++; if (bus.REQ !== 1'b0)  begin failures++; $display("FAIL basic_req_fall got=%b exp=0", bus.REQ); end
    bus.RES_READY = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (bus.RES_VALID !== 1'b0) begin failures++; $display("FAIL basic_drain got=%b exp=0", bus.RES_VALID); end
    bus.RES_READY = 1'b0;
    wait_idle();
  endtask

  task automatic test_dbz;
    int n;
    bus.RES_READY = 1'b0;
    push_cmd(16'd9, 16'd0);
    n = 0;
    while (!bus.REQ && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (!bus.FDBZ && n < 20) begin @(negedge clk); n++; end
    checks++; if (n > 2 || !bus.FDBZ) begin failures++; $display("FAIL dbz_latency got=%0d exp<=2", n); end
    checks++; if (bus.REQ !== 1'b1)   begin failures++; $display("FAIL dbz_req_with_fdbz got=%b exp=1", bus.REQ); end
    @(negedge clk);
    checks++; if (bus.REQ !== 1'b0)       begin failures++; $display("FAIL dbz_req_fall got=%b exp=0", bus.REQ); end
    checks++; if (bus.RES_VALID !== 1'b1) begin failures++; $display("FAIL dbz_valid got=%b exp=1", bus.RES_VALID); end
    checks++; if ({bus.RES_DBZ, bus.RES_TO} !== 2'b10) begin failures++; $display("FAIL dbz_flags got=%b exp=10", {bus.RES_DBZ, bus.RES_TO}); end
    checks++; if ({bus.RES_Q, bus.RES_R} !== 32'h0) begin failures++; $display("FAIL dbz_qr got=%h exp=00000000", {bus.RES_Q, bus.RES_R}); end
    bus.RES_READY = 1'b1;
    @(posedge clk); #1;
    bus.RES_READY = 1'b0;
    wait_idle();
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] ca[5], cd[5], eq[5], er[5], gq[5], gr[5];
    int n, k, bad_rise;
    logic prev_req, prev_ack;
    ca = '{16'd100, 16'd255, 16'd1000, 16'd7, 16'd65535};
    cd = '{16'd7,   16'd16,  16'd3,    16'd9, 16'd256};
    eq = '{16'd14,  16'd15,  16'd333,  16'd0, 16'd255};
    er = '{16'd2,   16'd15,  16'd1,    16'd7, 16'd255};
    ack_extra = 3; bus.RES_READY = 1'b1; ack_ovr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.CMD_A = ca[i]; bus.CMD_D = cd[i]; bus.CMD_VALID = 1'b1;
      checks++; if (bus.CMD_READY !== 1'b1) begin failures++; $display("FAIL b2b_fill_ready[%0d] got=%b exp=1", i, bus.CMD_READY); end
      @(posedge clk);
    end
    @(negedge clk);
    bus.CMD_A = ca[4]; bus.CMD_D = cd[4];
    checks++; if (bus.CMD_READY !== 1'b0) begin failures++; $display("FAIL b2b_full_ready got=%b exp=0", bus.CMD_READY); end
    repeat (3) @(negedge clk);
    checks++; if (bus.REQ !== 1'b0) begin failures++; $display("FAIL b2b_req_under_ack got=%b exp=0", bus.REQ); end
    ack_ovr = 1'b0;
    n = 0;
    while (!bus.CMD_READY && n < 50) begin @(negedge clk); n++; end
    checks++; if (bus.CMD_READY !== 1'b1) begin failures++; $display("FAIL b2b_fifth_ready got=%b exp=1", bus.CMD_READY); end
    @(posedge clk); #1;
    bus.CMD_VALID = 1'b0;
    k = 0; n = 0; bad_rise = 0;
    prev_req = bus.REQ; prev_ack = bus.ACK;
    while (k < 5 && n < 400) begin
      @(negedge clk); n++;
      if (bus.REQ && !prev_req && prev_ack) bad_rise++;
      prev_req = bus.REQ; prev_ack = bus.ACK;
      if (bus.RES_VALID) begin gq[k] = bus.RES_Q; gr[k] = bus.RES_R; k++; end
    end
    checks++; if (k != 5)        begin failures++; $display("FAIL b2b_count got=%0d exp=5", k); end
    checks++; if (bad_rise != 0) begin failures++; $display("FAIL b2b_req_rise_ack_high got=%0d exp=0", bad_rise); end
    for (int i = 0; i < k; i++) begin
      checks++; if (gq[i] !== eq[i]) begin failures++; $display("FAIL b2b_q[%0d] got=%h exp=%h", i, gq[i], eq[i]); end
      checks++; if (gr[i] !== er[i]) begin failures++; $display("FAIL b2b_r[%0d] got=%h exp=%h", i, gr[i], er[i]); end
    end
    ack_extra = 0;
    wait_idle();
  endtask

  task automatic test_backpressure;
    int n;
    bus.RES_READY = 1'b0;
    push_cmd(16'd20, 16'd6);
    push_cmd(16'd50, 16'd7);
    n = 0;
    while (!bus.RES_VALID && n < 100) begin @(negedge clk); n++; end
    checks++; if ({bus.RES_Q, bus.RES_R} !== {16'd3, 16'd2}) begin failures++; $display("FAIL bp_first got=%h exp=00030002", {bus.RES_Q, bus.RES_R}); end
    repeat (30) @(negedge clk);
    checks++; if ({bus.REQ, bus.ACK} !== 2'b11) begin failures++; $display("FAIL bp_req_ack_held got=%b exp=11", {bus.REQ, bus.ACK}); end
    checks++; if (bus.RES_VALID !== 1'b1 || bus.RES_Q !== 16'd3) begin failures++; $display("FAIL bp_slot_held got=%b/%h exp=1/0003", bus.RES_VALID, bus.RES_Q); end
    bus.RES_READY = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.RES_READY = 1'b0;
    checks++; if (bus.RES_VALID !== 1'b1) begin failures++; $display("FAIL bp_second_valid got=%b exp=1", bus.RES_VALID); end
    checks++; if ({bus.RES_Q, bus.RES_R} !== {16'd7, 16'd1}) begin failures++; $display("FAIL bp_second got=%h exp=00070001", {bus.RES_Q, bus.RES_R}); end
    checks++; if (bus.REQ !== 1'b0) begin failures++; $display("FAIL bp_req_fall got=%b exp=0", bus.REQ); end
    bus.RES_READY = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (bus.RES_VALID !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", bus.RES_VALID); end
    repeat (6) @(negedge clk);
    checks++; if (bus.RES_VALID !== 1'b0) begin failures++; $display("FAIL bp_no_dup got=%b exp=0", bus.RES_VALID); end
    bus.RES_READY = 1'b0;
    wait_idle();
  endtask

  task automatic test_timeout;
    int n;
    bus.RES_READY = 1'b0;
    silent = 1'b1;
    push_cmd(16'd1, 16'd1);
    n = 0;
    while (!bus.REQ && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (bus.REQ && n < 200) begin @(negedge clk); n++; end
    checks++; if (n != 64) begin failures++; $display("FAIL to_req_cycles got=%0d exp=64", n); end
    checks++; if (bus.RES_VALID !== 1'b1) begin failures++; $display("FAIL to_valid got=%b exp=1", bus.RES_VALID); end
    checks++; if ({bus.RES_DBZ, bus.RES_TO} !== 2'b01) begin failures++; $display("FAIL to_flags got=%b exp=01", {bus.RES_DBZ, bus.RES_TO}); end
    checks++; if ({bus.RES_Q, bus.RES_R} !== 32'h0) begin failures++; $display("FAIL to_qr got=%h exp=00000000", {bus.RES_Q, bus.RES_R}); end
    silent = 1'b0;
    bus.RES_READY = 1'b1;
    @(posedge clk); #1;
    bus.RES_READY = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset_mid;
    int n;
    bus.RES_READY = 1'b0;
    push_cmd(16'd30, 16'd4);
    push_cmd(16'd40, 16'd5);
    push_cmd(16'd11, 16'd3);
    n = 0;
    while (!bus.RES_VALID && n < 100) begin @(negedge clk); n++; end
    checks++; if (bus.RES_Q !== 16'd7) begin failures++; $display("FAIL rm_first_q got=%h exp=0007", bus.RES_Q); end
    n = 0;
    while (!bus.REQ && n < 20) begin @(negedge clk); n++; end
    repeat (8) @(negedge clk);
    rst = 1'b1; ack_ovr = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.REQ !== 1'b0)       begin failures++; $display("FAIL rm_req got=%b exp=0", bus.REQ); end
    checks++; if (bus.RES_VALID !== 1'b0) begin failures++; $display("FAIL rm_res_valid got=%b exp=0", bus.RES_VALID); end
    checks++; if (bus.BUSY !== 1'b0)      begin failures++; $display("FAIL rm_fifo_empty busy=%b exp=0", bus.BUSY); end
    push_cmd(16'd12, 16'd4);
    repeat (4) @(negedge clk);
    checks++; if (bus.REQ !== 1'b0) begin failures++; $display("FAIL rm_req_under_ack got=%b exp=0", bus.REQ); end
    ack_ovr = 1'b0;
    n = 0;
    while (!bus.REQ && n < 10) begin @(negedge clk); n++; end
    checks++; if (bus.REQ !== 1'b1 || bus.A !== 16'd12) begin failures++; $display("FAIL rm_reissue got=%b/%h exp=1/000c", bus.REQ, bus.A); end
    n = 0;
    while (!bus.RES_VALID && n < 40) begin @(negedge clk); n++; end
    checks++; if ({bus.RES_Q, bus.RES_R} !== {16'd3, 16'd0}) begin failures++; $display("FAIL rm_result got=%h exp=00030000", {bus.RES_Q, bus.RES_R}); end
    bus.RES_READY = 1'b1;
    @(posedge clk); #1;
    bus.RES_READY = 1'b0;
    wait_idle();
  endtask

  initial begin
    rst = 1'b1;
    bus.CMD_VALID = 1'b0;
    bus.CMD_A     = '0;
    bus.CMD_D     = '0;
    bus.RES_READY = 1'b0;
    test_reset();
    test_basic();
    test_dbz();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
